// File: rtl/bus_uart.sv
// bus_uart: memory-mapped UART with TX FIFO, RX buffer, programmable divisor and sticky errors.
// Define BUS_UART_RX_FIFO_EN to turn the single RX holding register into an RX_DEPTH-entry FIFO.
`timescale 1ns/1ps
module bus_uart #(
   parameter int CLK_HZ   = 25000000,
   parameter int BAUD     = 115200,
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cs,
   input  logic [1:0]  addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   input  logic        rxd,
   output logic        txd
);

   localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD);
   localparam int TAW = $clog2(TX_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // Handshake: cs is held until ready; ready pulses for exactly one cycle per access and the
   // access (push, pop, register write, rdata capture) happens on the edge that raises ready.
   logic acc, wr, rd;
   assign acc = cs && !ready;
   assign wr  = acc && (wstrb != 4'b0000);
   assign rd  = acc && (wstrb == 4'b0000);

   logic [15:0] div_q, div_new;
   logic        frame_err, rx_overrun;
   logic        rx_valid, rx_bfull, rx_pop, rx_push, rx_done, rx_ferr;
   logic [7:0]  rx_head;
   logic        unused_bits;
   assign unused_bits = ^wdata[31:16];

   // ---------------- TX FIFO ----------------
   logic [7:0]   tx_mem [TX_DEPTH];
   logic [TAW:0] tx_wp, tx_rp;
   logic         tx_empty, tx_full, tx_push, tx_pop, tx_load, tx_idle;
   logic [7:0]   tx_head;

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
   assign tx_head  = tx_mem[tx_rp[TAW-1:0]];
   assign tx_push  = wr && (addr == 2'd0) && wstrb[0] && !tx_full;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= wdata[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wp <= '0;
         tx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      end
   end

   // ---------------- TX FSM ----------------
   tx_state_t   tx_state, tx_state_d;
   logic [15:0] tx_cnt, tx_cnt_d, tx_div, tx_div_d;
   logic [7:0]  tx_sh, tx_sh_d;
   logic [2:0]  tx_bit, tx_bit_d;
   logic        txd_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_div   <= DIV_RST;
         tx_sh    <= '0;
         tx_bit   <= '0;
         txd      <= 1'b1;
      end else begin
         tx_state <= tx_state_d;
         tx_cnt   <= tx_cnt_d;
         tx_div   <= tx_div_d;
         tx_sh    <= tx_sh_d;
         tx_bit   <= tx_bit_d;
         txd      <= txd_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state;
      tx_cnt_d   = tx_cnt;
      tx_div_d   = tx_div;
      tx_sh_d    = tx_sh;
      tx_bit_d   = tx_bit;
      txd_d      = txd;
      tx_pop     = 1'b0;
      tx_load    = 1'b0;
      case (tx_state)
         TX_IDLE: tx_load = !tx_empty;
         TX_START: begin
            if (tx_cnt == 16'd0) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = tx_div - 16'd1;
               tx_bit_d   = 3'd0;
               txd_d      = tx_sh[0];
            end else begin
               tx_cnt_d = tx_cnt - 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_cnt == 16'd0) begin
               tx_cnt_d = tx_div - 16'd1;
               if (tx_bit == 3'd7) begin
                  tx_state_d = TX_STOP;
                  txd_d      = 1'b1;
               end else begin
                  tx_bit_d = tx_bit + 3'd1;
                  tx_sh_d  = {1'b0, tx_sh[7:1]};
                  txd_d    = tx_sh[1];
               end
            end else begin
               tx_cnt_d = tx_cnt - 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_cnt == 16'd0) begin
               if (tx_empty) tx_state_d = TX_IDLE;
               else          tx_load    = 1'b1;
            end else begin
               tx_cnt_d = tx_cnt - 16'd1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      // Loading straight from STOP gives back-to-back frames with no idle gap.
      if (tx_load) begin
         tx_pop     = 1'b1;
         tx_state_d = TX_START;
         tx_div_d   = div_q;
         tx_cnt_d   = div_q - 16'd1;
         tx_sh_d    = tx_head;
         txd_d      = 1'b0;
      end
   end

   assign tx_idle = tx_empty && (tx_state == TX_IDLE);

   // ---------------- RX synchronizer and FSM ----------------
   logic        rx_s1, rx_s2, rx_d;
   rx_state_t   rx_state, rx_state_d;
   logic [15:0] rx_cnt, rx_cnt_d, rx_div, rx_div_d;
   logic [7:0]  rx_sh, rx_sh_d;
   logic [2:0]  rx_bit, rx_bit_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_d     <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_div   <= DIV_RST;
         rx_sh    <= '0;
         rx_bit   <= '0;
      end else begin
         rx_s1    <= rxd;
         rx_s2    <= rx_s1;
         rx_d     <= rx_s2;
         rx_state <= rx_state_d;
         rx_cnt   <= rx_cnt_d;
         rx_div   <= rx_div_d;
         rx_sh    <= rx_sh_d;
         rx_bit   <= rx_bit_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state;
      rx_cnt_d   = rx_cnt;
      rx_div_d   = rx_div;
      rx_sh_d    = rx_sh;
      rx_bit_d   = rx_bit;
      rx_done    = 1'b0;
      rx_ferr    = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_d && !rx_s2) begin
               rx_state_d = RX_START;
               rx_div_d   = div_q;
               rx_cnt_d   = (div_q >> 1) - 16'd1;
            end
         end
         RX_START: begin
            if (rx_cnt == 16'd0) begin
               // A line already high again at mid-start was a glitch.
               rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
               rx_cnt_d   = rx_div - 16'd1;
               rx_bit_d   = 3'd0;
            end else begin
               rx_cnt_d = rx_cnt - 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_cnt == 16'd0) begin
               rx_sh_d  = {rx_s2, rx_sh[7:1]};
               rx_cnt_d = rx_div - 16'd1;
               rx_bit_d = rx_bit + 3'd1;
               if (rx_bit == 3'd7) rx_state_d = RX_STOP;
            end else begin
               rx_cnt_d = rx_cnt - 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt == 16'd0) begin
               rx_state_d = RX_IDLE;
               rx_done    = rx_s2;
               rx_ferr    = !rx_s2;
            end else begin
               rx_cnt_d = rx_cnt - 16'd1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- RX buffer ----------------
   assign rx_pop  = rd && (addr == 2'd0) && rx_valid;
   assign rx_push = rx_done && (!rx_bfull || rx_pop);

`ifdef BUS_UART_RX_FIFO_EN
   localparam int RAW = $clog2(RX_DEPTH);
   logic [7:0]   rx_mem [RX_DEPTH];
   logic [RAW:0] rx_wp, rx_rp;

   assign rx_valid = (rx_wp != rx_rp);
   assign rx_bfull = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
   assign rx_head  = rx_mem[rx_rp[RAW-1:0]];

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_sh;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
   end
`else
   logic [7:0]  rx_hold;
   logic        rx_hv;
   logic [31:0] unused_rx_depth;
   assign unused_rx_depth = RX_DEPTH;
   assign rx_valid = rx_hv;
   assign rx_bfull = rx_hv;
   assign rx_head  = rx_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_hold <= '0;
         rx_hv   <= 1'b0;
      end else if (rx_push) begin
         rx_hold <= rx_sh;
         rx_hv   <= 1'b1;
      end else if (rx_pop) begin
         rx_hv   <= 1'b0;
      end
   end
`endif

   // ---------------- registers and bus ----------------
   always_comb begin
      div_new = {wstrb[1] ? wdata[15:8] : div_q[15:8], wstrb[0] ? wdata[7:0] : div_q[7:0]};
      if (div_new < 16'd4) div_new = 16'd4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready      <= 1'b0;
         rdata      <= '0;
         div_q      <= DIV_RST;
         frame_err  <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         ready <= cs && !ready;
         if (wr && (addr == 2'd2)) div_q <= div_new;
         // Setting beats clearing when both land in the same cycle.
         if (rx_done && rx_bfull && !rx_pop)                 rx_overrun <= 1'b1;
         else if (wr && (addr == 2'd1) && wstrb[0] && wdata[3]) rx_overrun <= 1'b0;
         if (rx_ferr)                                        frame_err <= 1'b1;
         else if (wr && (addr == 2'd1) && wstrb[0] && wdata[4]) frame_err <= 1'b0;
         if (rd) begin
            case (addr)
               2'd0:    rdata <= rx_valid ? {23'b0, 1'b1, rx_head} : 32'd0;
               2'd1:    rdata <= {27'b0, frame_err, rx_overrun, rx_valid, tx_idle, tx_full};
               2'd2:    rdata <= {16'b0, div_q};
               default: rdata <= 32'd0;
            endcase
         end else if (acc) begin
            rdata <= 32'd0;
         end
      end
   end

endmodule
